// File: rtl/sram_seg_pkg.sv
// Shared types and elaboration-time helpers for the SRAM 7-segment bus monitor.
// Optional build macro used by this block: SRAM_SEG_SAT_EN (saturated out-of-range address field).
package sram_seg_pkg;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_BROWSE = 1'b1
  } state_e;

  // Entry layout in the default configuration (8-bit address field, 8-bit data).
  // The top re-declares the same field order sized by its own parameters.
  localparam int DEF_AF_W   = 8;
  localparam int DEF_DATA_W = 8;

  typedef struct packed {
    logic                  we;
    logic                  ovf;
    logic [DEF_AF_W-1:0]   addr_field;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Address field gets whatever hex digits the data field leaves over.
  function automatic int af_w(input int seg_digits, input int data_w);
    return 4 * seg_digits - data_w;
  endfunction

endpackage

// File: rtl/sram_seg_fmt.sv
// Address range check and address-field packing for one captured SRAM access.
// SRAM_SEG_SAT_EN selects all-ones instead of all-zeros for an out-of-range address.
module sram_seg_fmt
  import sram_seg_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int AF_W   = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [AF_W-1:0]   addr_field_o,
  output logic              ovf_o
);

  logic [AF_W-1:0] in_field;
  logic            out_of_range;

  // Out of range means any bit above the field is set, i.e. addr > 2^AF_W-1.
  if (ADDR_W > AF_W) begin : g_wide
    assign out_of_range = |addr_i[ADDR_W-1:AF_W];
    assign in_field     = addr_i[AF_W-1:0];
  end else begin : g_narrow
    assign out_of_range = 1'b0;
    assign in_field     = AF_W'(addr_i);
  end

  always_comb begin
    ovf_o = out_of_range;
`ifdef SRAM_SEG_SAT_EN
    addr_field_o = out_of_range ? '1 : in_field;
`else
    addr_field_o = out_of_range ? '0 : in_field;
`endif
  end

endmodule

// File: rtl/sram_seg_monitor.sv
// SRAM access history monitor: ring buffer of completed accesses, browse FSM and
// registered 7-segment display word. Build macro: SRAM_SEG_SAT_EN (see sram_seg_fmt).
module sram_seg_monitor
  import sram_seg_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 8,
  parameter int SEG_DIGITS = 4,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bus_valid,
  input  logic                          bus_we,
  input  logic [ADDR_W-1:0]             bus_addr,
  input  logic [DATA_W-1:0]             bus_data,
  input  logic                          btn_prev,
  input  logic                          btn_next,
  input  logic                          freeze,
  output logic [4*SEG_DIGITS-1:0]       data_to_seg,
  output logic                          entry_we,
  output logic                          entry_valid,
  output logic                          addr_ovf,
  output logic [clog2(HIST_DEPTH)-1:0]  view_ofs,
  output logic                          dropped
);

  localparam int DW   = 4 * SEG_DIGITS;
  localparam int AF_W = af_w(SEG_DIGITS, DATA_W);
  localparam int PW   = clog2(HIST_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(HIST_DEPTH);

  typedef struct packed {
    logic              we;
    logic              ovf;
    logic [AF_W-1:0]   addr_field;
    logic [DATA_W-1:0] data;
  } hist_entry_t;

  logic [AF_W-1:0] cap_field;
  logic            cap_ovf;
  hist_entry_t     new_entry;

  sram_seg_fmt #(
    .ADDR_W (ADDR_W),
    .AF_W   (AF_W)
  ) u_fmt (
    .addr_i       (bus_addr),
    .addr_field_o (cap_field),
    .ovf_o        (cap_ovf)
  );

  always_comb begin
    new_entry.we         = bus_we;
    new_entry.ovf        = cap_ovf;
    new_entry.addr_field = cap_field;
    new_entry.data       = bus_data;
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   view_q, view_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_idx;
  hist_entry_t     mem_q [HIST_DEPTH];
  hist_entry_t     sel_entry;

  logic            prev_only, next_only;
  logic            capture, drop;

  logic [DW-1:0]   seg_q;
  logic            we_q, valid_q, ovf_q, dropped_q;

  // Simultaneous prev and next cancel each other.
  assign prev_only = btn_prev & ~btn_next;
  assign next_only = btn_next & ~btn_prev;

  assign capture = bus_valid & ~freeze & (state_q == ST_LIVE) & ~rst;
  assign drop    = bus_valid & (freeze | (state_q == ST_BROWSE));

  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    case (state_q)
      ST_LIVE: begin
        if (prev_only && (count_q >= CW'(2))) begin
          state_d = ST_BROWSE;
          view_d  = PW'(1);
        end
      end
      ST_BROWSE: begin
        if (prev_only) begin
          if ({1'b0, view_q} < (count_q - CW'(1))) begin
            view_d = view_q + PW'(1);
          end
        end else if (next_only) begin
          if (view_q == PW'(1)) begin
            state_d = ST_LIVE;
            view_d  = '0;
          end else begin
            view_d = view_q - PW'(1);
          end
        end
      end
      default: begin
        state_d = ST_LIVE;
        view_d  = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (capture) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (count_q != FULL) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Display index is computed from next-state values so the output register
  // reflects a capture or button press one cycle later; a same-cycle write is bypassed.
  always_comb begin
    rd_idx = wr_ptr_d - PW'(1) - view_d;
    if (capture && (rd_idx == wr_ptr_q)) begin
      sel_entry = new_entry;
    end else begin
      sel_entry = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LIVE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      view_q    <= '0;
      seg_q     <= '0;
      we_q      <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      view_q    <= view_d;
      dropped_q <= dropped_q | drop;
      if (count_d == '0) begin
        seg_q   <= '0;
        we_q    <= 1'b0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        seg_q   <= {sel_entry.addr_field, sel_entry.data};
        we_q    <= sel_entry.we;
        valid_q <= 1'b1;
        ovf_q   <= sel_entry.ovf;
      end
    end
  end

  assign data_to_seg = seg_q;
  assign entry_we    = we_q;
  assign entry_valid = valid_q;
  assign addr_ovf    = ovf_q;
  assign view_ofs    = view_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_sram_seg_monitor.sv
// Directed bench for sram_seg_monitor at default parameters (AF_W = 8, 8-entry history).
module tb_sram_seg_monitor;

  logic        clk;
  logic        rst;
  logic        bus_valid;
  logic        bus_we;
  logic [22:0] bus_addr;
  logic [7:0]  bus_data;
  logic        btn_prev;
  logic        btn_next;
  logic        freeze;
  logic [15:0] data_to_seg;
  logic        entry_we;
  logic        entry_valid;
  logic        addr_ovf;
  logic [2:0]  view_ofs;
  logic        dropped;

`ifdef SRAM_SEG_SAT_EN
  localparam logic [7:0] OVF_FIELD = 8'hFF;
`else
  localparam logic [7:0] OVF_FIELD = 8'h00;
`endif

  sram_seg_monitor #(
    .ADDR_W     (23),
    .DATA_W     (8),
    .SEG_DIGITS (4),
    .HIST_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_valid   (bus_valid),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .btn_prev    (btn_prev),
    .btn_next    (btn_next),
    .freeze      (freeze),
    .data_to_seg (data_to_seg),
    .entry_we    (entry_we),
    .entry_valid (entry_valid),
    .addr_ovf    (addr_ovf),
    .view_ofs    (view_ofs),
    .dropped     (dropped)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] seg;
    logic        we;
    logic        valid;
    logic        ovf;
    logic [2:0]  view;
    logic        drp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input int tag, input logic [15:0] seg, input logic we,
                              input logic valid, input logic ovf, input logic [2:0] view,
                              input logic drp);
    exp_t e;
    e.tag   = 8'(tag);
    e.seg   = seg;
    e.we    = we;
    e.valid = valid;
    e.ovf   = ovf;
    e.view  = view;
    e.drp   = drp;
    return e;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s tag=%0d actual=%h required=%h", nm, tag, act, req);
    end
  endtask

  // Scoreboard monitor: outputs are registered, so each pushed expectation is due
  // at the negedge following the edge that sampled the stimulus.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("data_to_seg", int'(e.tag), data_to_seg, e.seg);
      chk("entry_we", int'(e.tag), 16'(entry_we), 16'(e.we));
      chk("entry_valid", int'(e.tag), 16'(entry_valid), 16'(e.valid));
      chk("addr_ovf", int'(e.tag), 16'(addr_ovf), 16'(e.ovf));
      chk("view_ofs", int'(e.tag), 16'(view_ofs), 16'(e.view));
      chk("dropped", int'(e.tag), 16'(dropped), 16'(e.drp));
    end
  end

  // Driver tasks
  task automatic set_idle();
    rst       = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_data  = '0;
    btn_prev  = 1'b0;
    btn_next  = 1'b0;
    freeze    = 1'b0;
  endtask

  task automatic strobe(input logic we, input logic [22:0] a, input logic [7:0] d);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = a;
    bus_data  = d;
  endtask

  task automatic step(input exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    set_idle();
  endtask

  initial begin
    int          v;
    logic [7:0]  e8;
    set_idle();

    rst = 1'b1; step(mk(1, 16'h0000, 0, 0, 0, 0, 0));
    rst = 1'b1; step(mk(1, 16'h0000, 0, 0, 0, 0, 0));
    step(mk(2, 16'h0000, 0, 0, 0, 0, 0));

    strobe(1'b1, 23'h000012, 8'hAB); step(mk(3, 16'h12AB, 1, 1, 0, 0, 0));
    step(mk(3, 16'h12AB, 1, 1, 0, 0, 0));

    strobe(1'b0, 23'h000100, 8'h5C); step(mk(4, {OVF_FIELD, 8'h5C}, 0, 1, 1, 0, 0));
    strobe(1'b0, 23'h0000FF, 8'h01); step(mk(4, 16'hFF01, 0, 1, 0, 0, 0));
    strobe(1'b1, 23'h400000, 8'h77); step(mk(4, {OVF_FIELD, 8'h77}, 1, 1, 1, 0, 0));

    // A single entry is not enough to enter browse.
    rst = 1'b1; step(mk(5, 16'h0000, 0, 0, 0, 0, 0));
    strobe(1'b1, 23'h000005, 8'h06); step(mk(5, 16'h0506, 1, 1, 0, 0, 0));
    btn_prev = 1'b1; step(mk(5, 16'h0506, 1, 1, 0, 0, 0));

    rst = 1'b1; step(mk(6, 16'h0000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      e8 = 8'(i);
      strobe(e8[0], 23'(i), e8);
      step(mk(6, {e8, e8}, e8[0], 1, 0, 0, 0));
    end

    // History now holds 2..9; view saturates at 7.
    for (int p = 1; p <= 9; p++) begin
      v  = (p > 7) ? 7 : p;
      e8 = 8'(9 - v);
      btn_prev = 1'b1;
      step(mk(7, {e8, e8}, e8[0], 1, 0, 3'(v), 0));
    end

    strobe(1'b1, 23'h000033, 8'h33); step(mk(8, 16'h0202, 0, 1, 0, 7, 1));
    btn_prev = 1'b1; btn_next = 1'b1; step(mk(9, 16'h0202, 0, 1, 0, 7, 1));

    for (int n = 1; n <= 7; n++) begin
      v  = 7 - n;
      e8 = 8'(9 - v);
      btn_next = 1'b1;
      step(mk(10, {e8, e8}, e8[0], 1, 0, 3'(v), 1));
    end

    rst = 1'b1; step(mk(11, 16'h0000, 0, 0, 0, 0, 0));
    strobe(1'b1, 23'h000001, 8'h11); step(mk(11, 16'h0111, 1, 1, 0, 0, 0));
    freeze = 1'b1; strobe(1'b0, 23'h000033, 8'h33); step(mk(12, 16'h0111, 1, 1, 0, 0, 1));

    strobe(1'b0, 23'h000002, 8'h22); step(mk(13, 16'h0222, 0, 1, 0, 0, 1));
    btn_prev = 1'b1; step(mk(13, 16'h0111, 1, 1, 0, 1, 1));
    rst = 1'b1; strobe(1'b1, 23'h000044, 8'h44); step(mk(14, 16'h0000, 0, 0, 0, 0, 0));
    step(mk(14, 16'h0000, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    chk("exp_q_drained", 0, 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_seg_monitor.md
Name: sram_seg_monitor

Overview:
- Parametrised SRAM bus monitor for the 7-segment display path.
- Captures completed SRAM accesses (address, data, read/write) into a small ring-buffer history.
- Formats the selected entry into a {address-field, data-field} display word; address values too large for the field are flagged.
- Sits between the SRAM controller strobes and the seven-segment driver; the user browses history with debounced prev/next pulses.

Parameters:
- ADDR_W, 23, SRAM address width.
- DATA_W, 8, SRAM data width; must be a multiple of 4.
- SEG_DIGITS, 4, hex digits on the display; 4*SEG_DIGITS must exceed DATA_W.
- HIST_DEPTH, 8, history entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_valid  in  1  one-cycle strobe: an SRAM access completed this cycle.
- bus_we  in  1  1 = write, 0 = read; sampled with bus_valid.
- bus_addr  in  ADDR_W  access address; sampled with bus_valid.
- bus_data  in  DATA_W  write data or read return; sampled with bus_valid.
- btn_prev  in  1  one-cycle pulse: step to an older entry.
- btn_next  in  1  one-cycle pulse: step to a newer entry.
- freeze  in  1  level: while high, captures are dropped.
- data_to_seg  out  4*SEG_DIGITS  display word {addr_field, data_field}.
- entry_we  out  1  bus_we of the displayed entry.
- entry_valid  out  1  the displayed entry holds captured data.
- addr_ovf  out  1  the displayed entry's address exceeded the address field.
- view_ofs  out  clog2(HIST_DEPTH)  offset from newest; 0 = live view.
- dropped  out  1  sticky: a capture was dropped.

Behaviour:
- Field widths: AF_W = 4*SEG_DIGITS - DATA_W. addr_field = bus_addr[AF_W-1:0] if bus_addr <= 2^AF_W-1, else all zeros with the stored ovf bit set. The comparison uses the full ADDR_W value.
- Storage: each entry is {we, ovf, addr_field, data}. The write pointer wr_ptr wraps modulo HIST_DEPTH. count saturates at HIST_DEPTH; once full, the oldest entry is overwritten.
- FSM states and transitions:
  - LIVE: view_ofs = 0; accepts captures.
  - LIVE -> BROWSE on btn_prev when count >= 2; view_ofs becomes 1.
  - BROWSE: btn_prev increments view_ofs, holding at count-1; btn_next decrements it.
  - BROWSE -> LIVE when btn_next is pressed at view_ofs = 1.
  - btn_prev and btn_next in the same cycle: both ignored.
- Capture rule: capture when bus_valid && !freeze && state == LIVE.
- Drop rule: bus_valid arriving in BROWSE or with freeze=1 is dropped and sets dropped. dropped clears only on rst.
- Displayed entry index: (wr_ptr - 1 - view_ofs) mod HIST_DEPTH.
- Output timing: outputs are registered. A capture in cycle N appears on data_to_seg in cycle N+1. A button in cycle N changes the display in cycle N+1.
- Empty (count = 0): data_to_seg = 0, entry_valid = 0, entry_we = 0, addr_ovf = 0.
- Reset: all outputs 0, state LIVE, wr_ptr = 0, count = 0, dropped = 0. Storage contents need not clear, because count gates validity. rst wins over every simultaneous strobe; reset mid-browse returns to LIVE empty.

Optional Feature:
- Macro: SRAM_SEG_SAT_EN.
- Defined: an out-of-range address shows as all ones (saturated "FF..") instead of zeros. addr_ovf still asserts.
- Undefined: an out-of-range address shows as zeros.

Decomposition:
- Shared package sram_seg_pkg holds:
  - state enum {LIVE, BROWSE};
  - entry struct {we, ovf, addr_field, data};
  - AF_W derivation function;
  - the clog2 helper.
- One sub-module, sram_seg_fmt: combinational address-range check and field packing, with the SRAM_SEG_SAT_EN select. The top holds the ring buffer, FSM and output registers.

Test Plan (all at defaults, AF_W = 8):
- Reset then idle -> data_to_seg = 0x0000, entry_valid = 0, view_ofs = 0, dropped = 0.
- Write strobe addr = 0x000012, data = 0xAB -> next cycle data_to_seg = 0x12AB, entry_we = 1, addr_ovf = 0.
- Read strobe addr = 0x000100, data = 0x5C -> data_to_seg = 0x005C, addr_ovf = 1; with SRAM_SEG_SAT_EN, data_to_seg = 0xFF5C.
- 10 captures with addr = i, data = i (i = 0..9), then 9 btn_prev -> view_ofs holds at 7, display 0x0202. Then 7 btn_next -> LIVE, display 0x0909.
- In BROWSE, strobe addr = 0x33 -> dropped = 1, history unchanged. Same with freeze = 1 in LIVE.
- btn_prev and btn_next together -> no change. rst asserted mid-browse with bus_valid high -> reset state, nothing captured.
